// File: rtl/banner_sequencer.sv
// Title/countdown/game-over banner sequencer for the pong overlay.
// Optional pause support is compiled in with `define BANNER_PAUSE_EN.
module banner_sequencer #(
   parameter int unsigned COUNT_FRAMES = 60,
   parameter int unsigned GO_FRAMES    = 30,
   parameter int unsigned BLINK_FRAMES = 30,
   parameter int unsigned OVER_FRAMES  = 300,
   parameter int unsigned CHAR_PITCH   = 28
) (
   input  logic       clk_0,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       start,
   input  logic       game_over,
   input  logic       winner,
   input  logic       pause,
   output logic [3:0] msg_sel,
   output logic       msg_visible,
   output logic [9:0] x_pos,
   output logic [9:0] y_pos,
   output logic       play_en
);

   localparam int unsigned CNT_W = 16;

   typedef enum logic [2:0] {
      ATTRACT, COUNT3, COUNT2, COUNT1, GO, PLAY, OVER, PAUSED
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] frame_cnt, blink_cnt;
   logic             start_pend, over_pend, winner_pend;
   logic             start_hit, over_hit, start_eff, over_eff, winner_eff;
   logic             blink_wrap;
   logic [3:0]       sel_nxt;
   logic             vis_nxt, play_nxt;
   logic [9:0]       x_nxt;

   // Centre the string on a 640-pixel line; 0 when nothing is shown.
   function automatic logic [9:0] x_of(input logic [3:0] sel);
      int unsigned len;
      case (sel)
         4'd1:             len = 11;
         4'd2, 4'd3, 4'd4: len = 1;
         4'd5:             len = 2;
         4'd6, 4'd7:       len = 7;
         4'd8:             len = 6;
         default:          len = 0;
      endcase
      if (len == 0) return '0;
      return 10'((640 - len * CHAR_PITCH) / 2);
   endfunction

   always_comb begin
      start_hit  = start && (state == ATTRACT || state == OVER);
      over_hit   = game_over && (state == PLAY);
      start_eff  = start_pend | start_hit;
      over_eff   = over_pend | over_hit;
      winner_eff = over_hit ? winner : winner_pend;
      blink_wrap = (blink_cnt == CNT_W'(BLINK_FRAMES - 1));
   end

`ifdef BANNER_PAUSE_EN
   logic pause_pend, pause_hit, pause_eff;

   always_comb begin
      pause_hit = pause && (state == PLAY || state == PAUSED);
      pause_eff = pause_pend | pause_hit;
   end
`else
   logic unused_pause;
   assign unused_pause = pause;
`endif

   always_ff @(posedge clk_0 or posedge rst) begin
      if (rst) begin
         state       <= ATTRACT;
         frame_cnt   <= '0;
         blink_cnt   <= '0;
         start_pend  <= 1'b0;
         over_pend   <= 1'b0;
         winner_pend <= 1'b0;
`ifdef BANNER_PAUSE_EN
         pause_pend  <= 1'b0;
`endif
         msg_sel     <= 4'd1;
         msg_visible <= 1'b1;
         x_pos       <= x_of(4'd1);
         y_pos       <= 10'd224;
         play_en     <= 1'b0;
      end else begin
         y_pos <= 10'd224;
         // winner is data, not a pending flag: it must survive the PLAY->OVER change
         if (over_hit) winner_pend <= winner;
         if (frame_tick && state_nxt != state) begin
            state      <= state_nxt;
            frame_cnt  <= '0;
            blink_cnt  <= '0;
            start_pend <= 1'b0;
            over_pend  <= 1'b0;
`ifdef BANNER_PAUSE_EN
            pause_pend <= 1'b0;
`endif
         end else begin
            if (frame_tick) begin
               frame_cnt <= frame_cnt + 1'b1;
               blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
            end
            start_pend <= start_eff;
            over_pend  <= over_eff;
`ifdef BANNER_PAUSE_EN
            pause_pend <= pause_eff;
`endif
         end
         if (frame_tick) begin
            msg_sel     <= sel_nxt;
            msg_visible <= vis_nxt;
            x_pos       <= x_nxt;
            play_en     <= play_nxt;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      if (frame_tick) begin
         case (state)
            ATTRACT: if (start_eff) state_nxt = COUNT3;
            COUNT3:  if (frame_cnt == CNT_W'(COUNT_FRAMES - 1)) state_nxt = COUNT2;
            COUNT2:  if (frame_cnt == CNT_W'(COUNT_FRAMES - 1)) state_nxt = COUNT1;
            COUNT1:  if (frame_cnt == CNT_W'(COUNT_FRAMES - 1)) state_nxt = GO;
            GO:      if (frame_cnt == CNT_W'(GO_FRAMES - 1)) state_nxt = PLAY;
`ifdef BANNER_PAUSE_EN
            PLAY: begin
               if (over_eff)       state_nxt = OVER;
               else if (pause_eff) state_nxt = PAUSED;
            end
            PAUSED:  if (pause_eff) state_nxt = COUNT3;
`else
            PLAY:    if (over_eff) state_nxt = OVER;
`endif
            OVER: begin
               if (start_eff)                                   state_nxt = COUNT3;
               else if (frame_cnt == CNT_W'(OVER_FRAMES - 1)) state_nxt = ATTRACT;
            end
            default: state_nxt = ATTRACT;
         endcase
      end
   end

   always_comb begin
      sel_nxt  = '0;
      play_nxt = 1'b0;
      case (state_nxt)
         ATTRACT: sel_nxt = 4'd1;
         COUNT3:  sel_nxt = 4'd2;
         COUNT2:  sel_nxt = 4'd3;
         COUNT1:  sel_nxt = 4'd4;
         GO:      sel_nxt = 4'd5;
         PLAY:    play_nxt = 1'b1;
         OVER:    sel_nxt = 4'd6 + {3'b000, winner_eff};
`ifdef BANNER_PAUSE_EN
         PAUSED:  sel_nxt = 4'd8;
`endif
         default: sel_nxt = '0;
      endcase
      x_nxt = x_of(sel_nxt);
      if (state_nxt == ATTRACT || state_nxt == OVER) begin
         if (state_nxt != state) vis_nxt = 1'b1;
         else if (blink_wrap)    vis_nxt = ~msg_visible;
         else                    vis_nxt = msg_visible;
      end else begin
         vis_nxt = (sel_nxt != 4'd0);
      end
   end

endmodule

// File: tb/tb_banner_sequencer.sv
// Scoreboard bench for banner_sequencer: expectations are queued per frame tick
// and compared one cycle after the tick that should produce them.
module tb_banner_sequencer;

   logic       clk_0 = 1'b0;
   logic       rst = 1'b1;
   logic       frame_tick = 1'b0;
   logic       start = 1'b0;
   logic       game_over = 1'b0;
   logic       winner = 1'b0;
   logic       pause = 1'b0;
   logic [3:0] msg_sel;
   logic       msg_visible;
   logic [9:0] x_pos;
   logic [9:0] y_pos;
   logic       play_en;

   banner_sequencer #(
      .COUNT_FRAMES(60),
      .GO_FRAMES(30),
      .BLINK_FRAMES(30),
      .OVER_FRAMES(300),
      .CHAR_PITCH(28)
   ) dut (
      .clk_0(clk_0),
      .rst(rst),
      .frame_tick(frame_tick),
      .start(start),
      .game_over(game_over),
      .winner(winner),
      .pause(pause),
      .msg_sel(msg_sel),
      .msg_visible(msg_visible),
      .x_pos(x_pos),
      .y_pos(y_pos),
      .play_en(play_en)
   );

   always #5 clk_0 = ~clk_0;

   typedef struct {
      int unsigned at;
      string       tag;
      int          sel;
      int          x;
      int          pe;
      int          vis;
   } exp_t;

   exp_t        sb[$];
   int unsigned total = 0;
   int unsigned bad = 0;
   int unsigned t = 0;
   int unsigned mon_t = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic push(input int unsigned at, input string tag, input int sel,
                       input int x, input int pe, input int vis);
      exp_t e;
      e.at = at; e.tag = tag; e.sel = sel; e.x = x; e.pe = pe; e.vis = vis;
      sb.push_back(e);
   endtask

   task automatic one_tick();
      @(negedge clk_0) frame_tick = 1'b1;
      t++;
      @(negedge clk_0) frame_tick = 1'b0;
      @(negedge clk_0);
      @(negedge clk_0);
   endtask

   task automatic run_to(input int unsigned target);
      while (t < target) one_tick();
   endtask

   task automatic pulse_start();
      @(negedge clk_0) start = 1'b1;
      @(negedge clk_0) start = 1'b0;
   endtask

   task automatic pulse_pause();
      @(negedge clk_0) pause = 1'b1;
      @(negedge clk_0) pause = 1'b0;
   endtask

   // winner flips right after the pulse so only the sampled value can be used
   task automatic pulse_over(input logic w);
      @(negedge clk_0) begin game_over = 1'b1; winner = w; end
      @(negedge clk_0) begin game_over = 1'b0; winner = ~w; end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk_0);
         if (frame_tick && !rst) begin
            mon_t++;
            #1;
            while (sb.size() > 0 && sb[0].at <= mon_t) begin
               e = sb.pop_front();
               if (e.at != mon_t) check_eq({e.tag, "_missed"}, mon_t, e.at);
               check_eq({e.tag, "_sel"}, 32'(msg_sel), e.sel);
               check_eq({e.tag, "_x"}, 32'(x_pos), e.x);
               check_eq({e.tag, "_y"}, 32'(y_pos), 224);
               check_eq({e.tag, "_play"}, 32'(play_en), e.pe);
               if (e.vis >= 0) check_eq({e.tag, "_vis"}, 32'(msg_visible), e.vis);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned play_t;
      int unsigned base;

      repeat (3) @(negedge clk_0);
      check_eq("rst_sel", 32'(msg_sel), 1);
      check_eq("rst_vis", 32'(msg_visible), 1);
      check_eq("rst_x", 32'(x_pos), 166);
      check_eq("rst_y", 32'(y_pos), 224);
      check_eq("rst_play", 32'(play_en), 0);
      rst = 1'b0;

      push(1, "attract1", 1, 166, 0, 1);
      push(29, "blink29", 1, 166, 0, 1);
      push(30, "blink30", 1, 166, 0, 0);
      push(60, "blink60", 1, 166, 0, 1);
      run_to(60);

      pulse_start();
      check_eq("midframe_sel", 32'(msg_sel), 1);
      push(61, "cnt3", 2, 306, 0, 1);
      push(120, "cnt3_hold", 2, 306, 0, 1);
      push(121, "cnt2", 3, 306, 0, 1);
      push(180, "cnt2_hold", 3, 306, 0, 1);
      push(181, "cnt1", 4, 306, 0, 1);
      push(240, "cnt1_hold", 4, 306, 0, 1);
      push(241, "go", 5, 292, 0, 1);
      push(270, "go_hold", 5, 292, 0, 1);
      push(271, "play", 0, 0, 1, 0);
      run_to(130);
      pulse_start();
      run_to(250);
      pulse_over(1'b1);
      run_to(290);

      pulse_over(1'b1);
      check_eq("over_midframe_play", 32'(play_en), 1);
      push(291, "p2wins", 7, 222, 0, 1);
      push(320, "over_blink_hold", 7, 222, 0, 1);
      push(321, "over_blink", 7, 222, 0, 0);
      push(590, "over_hold", 7, 222, 0, -1);
      push(591, "over_exit", 1, 166, 0, 1);
      run_to(600);

      pulse_start();
      push(601, "restart", 2, 306, 0, 1);
      push(811, "play2", 0, 0, 1, 0);
      run_to(820);
      pulse_pause();
`ifdef BANNER_PAUSE_EN
      push(821, "paused", 8, 236, 0, 1);
      push(825, "paused_hold", 8, 236, 0, 1);
      run_to(821);
      pulse_over(1'b0);
      run_to(825);
      pulse_pause();
      push(826, "resume", 2, 306, 0, 1);
      play_t = 826 + 3 * 60 + 30;
      push(play_t, "play3", 0, 0, 1, 0);
      run_to(play_t);
`else
      push(821, "pause_ignored", 0, 0, 1, 0);
      push(830, "pause_ignored_hold", 0, 0, 1, 0);
      run_to(830);
      play_t = 830;
`endif

      push(play_t + 6, "p1wins", 6, 222, 0, 1);
      run_to(play_t + 5);
      pulse_over(1'b0);
      run_to(play_t + 10);
      pulse_start();
      push(play_t + 11, "over_start", 2, 306, 0, 1);
      push(play_t + 71, "cnt2_again", 3, 306, 0, 1);
      push(play_t + 131, "cnt1_again", 4, 306, 0, 1);
      run_to(play_t + 135);

      @(posedge clk_0);
      #2 rst = 1'b1;
      #1;
      check_eq("arst_sel", 32'(msg_sel), 1);
      check_eq("arst_x", 32'(x_pos), 166);
      check_eq("arst_vis", 32'(msg_visible), 1);
      check_eq("arst_play", 32'(play_en), 0);
      @(negedge clk_0) rst = 1'b0;
      base = t;
      push(base + 1, "after_rst", 1, 166, 0, 1);
      push(base + 20, "no_resume", 1, 166, 0, 1);
      run_to(base + 20);

      repeat (5) @(negedge clk_0);
      check_eq("sb_drain", sb.size(), 0);
      check_eq("tick_count", mon_t, t);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/banner_sequencer.md
BANNER_SEQUENCER -- requirements
Module: banner_sequencer

Interface
REQ-001 SHALL have parameter COUNT_FRAMES, default 60: frames each countdown digit is shown.
REQ-002 SHALL have parameter GO_FRAMES, default 30: frames "GO" is shown.
REQ-003 SHALL have parameter BLINK_FRAMES, default 30: blink half-period, in frames.
REQ-004 SHALL have parameter OVER_FRAMES, default 300: frames in OVER before auto-return to ATTRACT.
REQ-005 SHALL have parameter CHAR_PITCH, default 28: glyph width plus kerning, in pixels.
REQ-006 SHALL have port clk_0, input, 1: pixel clock.
REQ-007 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port frame_tick, input, 1: one-cycle pulse at the start of each vertical blank.
REQ-009 SHALL have port start, input, 1: debounced start pulse.
REQ-010 SHALL have port game_over, input, 1: pulse; a player reached the winning score.
REQ-011 SHALL have port winner, input, 1: 0 = P1, 1 = P2; sampled together with game_over.
REQ-012 SHALL have port pause, input, 1: toggle pulse; used only under REQ-032.
REQ-013 SHALL have port msg_sel, output, 4: 0 none, 1 "PRESS START", 2 "3", 3 "2", 4 "1", 5 "GO", 6 "P1 WINS", 7 "P2 WINS", 8 "PAUSED".
REQ-014 SHALL have port msg_visible, output, 1: overlay enable.
REQ-015 SHALL have port x_pos, output, 10: top-left x of the current string.
REQ-016 SHALL have port y_pos, output, 10: top-left y of the current string.
REQ-017 SHALL have port play_en, output, 1: ball and paddle logic run enable.

Function
REQ-018 SHALL implement the states ATTRACT, COUNT3, COUNT2, COUNT1, GO, PLAY, OVER and PAUSED (PAUSED only per REQ-032).
REQ-019 SHALL latch start, game_over (with winner) and pause into pending flags on any cycle; all state changes SHALL occur only on a frame_tick cycle, using the pending flags plus any same-cycle pulse.
REQ-020 SHALL apply these transitions:
  - ATTRACT -start-> COUNT3
  - COUNTn -after COUNT_FRAMES ticks-> next digit
  - COUNT1 -> GO
  - GO -after GO_FRAMES ticks-> PLAY
  - PLAY -game_over-> OVER
  - OVER -start-> COUNT3
  - OVER -after OVER_FRAMES ticks-> ATTRACT
REQ-021 SHALL clear all pending flags on every state change; start pulses outside ATTRACT/OVER and game_over pulses outside PLAY SHALL be discarded.
REQ-022 SHALL give game_over priority over pause when both are pending in PLAY.
REQ-023 SHALL use a frame counter of at least 10 bits, cleared on state entry and incremented per frame_tick; a state exits when counter equals its parameter minus 1 on a tick.
REQ-024 SHALL toggle msg_visible every BLINK_FRAMES ticks in ATTRACT and OVER, starting visible on entry; in all other states msg_visible = (msg_sel != 0).
REQ-025 SHALL drive msg_sel per state: ATTRACT 1, COUNT3/2/1 2/3/4, GO 5, PLAY 0, OVER 6+winner, PAUSED 8.
REQ-026 SHALL set x_pos = (640 - LEN*CHAR_PITCH)/2 (truncating, LEN = string length), i.e. 166, 306, 306, 306, 292, 222, 222, 236 for msg_sel 1-8, and 0 when msg_sel = 0.
REQ-027 SHALL set y_pos = 224 constant.
REQ-028 SHALL assert play_en only in PLAY.
REQ-029 SHALL register all outputs, each updating in the cycle after the frame_tick that caused the state change, so no output changes mid-frame.

Reset
REQ-030 SHALL on rst asynchronously enter ATTRACT with counter 0, pending flags clear, msg_sel 1, msg_visible 1, x_pos 166, y_pos 224, play_en 0.
REQ-031 SHALL, on rst asserted mid-countdown or in PLAY, abandon the sequence and require a new start.

Configuration
REQ-032 SHALL support macro BANNER_PAUSE_EN:
  - Defined: pause in PLAY -> PAUSED (play_en 0, msg_sel 8); pause in PAUSED -> COUNT3 (resume countdown); game_over is ignored in PAUSED.
  - Undefined: pause is ignored, PAUSED is unreachable, msg_sel never 8.

Verification
REQ-033 SHALL cover reset then one tick: msg_sel 1, x_pos 166, msg_visible 1; after 30 ticks msg_visible 0; after 60 ticks msg_visible 1.
REQ-034 SHALL cover a start pulse mid-frame: no change until the next tick; then msg_sel 2, x_pos 306; after 60/120/180 ticks msg_sel 3/4/5; after 30 more ticks msg_sel 0 and play_en 1.
REQ-035 SHALL cover game_over with winner = 1 in PLAY: next tick gives msg_sel 7, x_pos 222, play_en 0; 300 ticks later msg_sel 1.
REQ-036 SHALL cover start during COUNT2 and game_over during GO: both ignored, timing unchanged.
REQ-037 SHALL cover, with BANNER_PAUSE_EN, pause in PLAY: msg_sel 8, x_pos 236, play_en 0; a second pause gives msg_sel 2. Without the macro, play_en stays 1.
REQ-038 SHALL cover rst asserted during COUNT1: outputs take the reset values immediately, without waiting for a clock edge.
